// File: rtl/io_pkg.sv
// io_pkg: definitions shared by the IO region responder, its timer and the
// system address decoder.
//   - io_state_e      : bus handshake FSM states
//   - IO_*_OFS        : word-aligned register byte offsets inside the region
//   - CTRL_*_BIT      : bit positions inside the CTRL register
//   - IO_BASE/IO_LIMIT: inclusive bounds of the IO region on the system bus
//   - io_merge_bytes  : applies a 4-lane byte-enabled write to a 32-bit word
package io_pkg;

  typedef enum logic [1:0] {
    IO_IDLE = 2'd0,
    IO_WAIT = 2'd1,
    IO_ACK  = 2'd2,
    IO_DONE = 2'd3
  } io_state_e;

  localparam logic [15:0] IO_LED_OFS    = 16'h0000;
  localparam logic [15:0] IO_SW_OFS     = 16'h0004;
  localparam logic [15:0] IO_TCOUNT_OFS = 16'h0008;
  localparam logic [15:0] IO_TCMP_OFS   = 16'h000C;
  localparam logic [15:0] IO_CTRL_OFS   = 16'h0010;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLAG_BIT  = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  localparam logic [31:0] IO_BASE  = 32'h0040_0000;
  localparam logic [31:0] IO_LIMIT = 32'h0040_FFFF;

  function automatic logic [31:0] io_merge_bytes(input logic [31:0] cur,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/io_timer.sv
// io_timer: prescaled compare timer for the IO region.
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   tcount_we, tcmp_we,
//   ctrl_we              : one-cycle bus write strobes for TCOUNT/TCOMPARE/CTRL
//   wdata, be            : bus write data and byte lanes
//   tcount, tcmp         : current TCOUNT / TCOMPARE values
//   ctrl_rd              : CTRL read view {irq_en, flag, enable}
//   irq                  : registered flag & irq_en
module io_timer
  import io_pkg::*;
#(
  parameter int PRESCALE = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tcount_we,
  input  logic        tcmp_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] tcount,
  output logic [31:0] tcmp,
  output logic [31:0] ctrl_rd,
  output logic        irq
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic          en;
  logic          irq_en;
  logic          flag;
  logic          tick;
  logic          match;
  logic          flag_clr;

  assign tick     = en && (pre == PRE_LAST);
  // A bus write to TCOUNT drops the coincident tick, so it cannot match either.
  assign match    = tick && !tcount_we && (tcount == tcmp);
  assign flag_clr = ctrl_we && be[0] && wdata[CTRL_FLAG_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      pre    <= '0;
      en     <= 1'b0;
      irq_en <= 1'b0;
      flag   <= 1'b0;
      tcount <= '0;
      tcmp   <= '0;
      irq    <= 1'b0;
    end else begin
      if (en) pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);

      if (tcount_we)  tcount <= io_merge_bytes(tcount, wdata, be);
      else if (tick)  tcount <= (tcount == tcmp) ? 32'd0 : tcount + 32'd1;

      if (tcmp_we) tcmp <= io_merge_bytes(tcmp, wdata, be);

      if (ctrl_we && be[0]) begin
        en     <= wdata[CTRL_EN_BIT];
        irq_en <= wdata[CTRL_IRQEN_BIT];
      end

      // Set has priority over write-1-to-clear.
      if (match)         flag <= 1'b1;
      else if (flag_clr) flag <= 1'b0;

      irq <= flag & irq_en;
    end
  end

  always_comb begin
    ctrl_rd                 = '0;
    ctrl_rd[CTRL_EN_BIT]    = en;
    ctrl_rd[CTRL_FLAG_BIT]  = flag;
    ctrl_rd[CTRL_IRQEN_BIT] = irq_en;
  end

endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder: bus target for the IO region 0x00400000-0x0040FFFF.
// Accepts a held Read_H/Write_H request while IO_Select_H is high, waits
// WAIT_STATES cycles, acknowledges for one cycle and then waits for the
// request to be withdrawn before accepting another.
// Ports:
//   Clock, Reset_H      : clock and synchronous active-high reset
//   IO_Select_H         : address decoder hit for the IO region
//   Address             : byte offset inside the region (bits [1:0] ignored)
//   Read_H, Write_H     : request strobes, held until acknowledged
//   ByteEnable          : write byte lanes
//   WriteData           : write data
//   ReadData            : read data, zero except while DataAck_H is high
//   DataAck_H           : one-cycle transfer acknowledge
//   LED                 : LED register
//   SW                  : asynchronous switch inputs
//   Timer_IRQ_H         : timer match interrupt (level)
module io_bus_responder
  import io_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int LED_WIDTH   = 10,
  parameter int SW_WIDTH    = 10,
  parameter int PRESCALE    = 50
) (
  input  logic                 Clock,
  input  logic                 Reset_H,
  input  logic                 IO_Select_H,
  input  logic [15:0]          Address,
  input  logic                 Read_H,
  input  logic                 Write_H,
  input  logic [3:0]           ByteEnable,
  input  logic [31:0]          WriteData,
  output logic [31:0]          ReadData,
  output logic                 DataAck_H,
  output logic [LED_WIDTH-1:0] LED,
  input  logic [SW_WIDTH-1:0]  SW,
  output logic                 Timer_IRQ_H
);

  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  io_state_e            state;
  io_state_e            state_nxt;
  logic [3:0]           ws_cnt;
  logic [15:0]          addr_q;
  logic [3:0]           be_q;
  logic [31:0]          wdata_q;
  logic                 wr_q;
  logic [SW_WIDTH-1:0]  sw_meta;
  logic [SW_WIDTH-1:0]  sw_sync;
  logic [LED_WIDTH-1:0] led_nxt;

  logic                 req_valid;
  logic [15:0]          word_addr;
  logic [15:0]          req_addr;
  logic                 go_ack;
  logic                 commit;
  logic [31:0]          rd_mux;

  logic [31:0]          tcount;
  logic [31:0]          tcmp;
  logic [31:0]          ctrl_rd;

  assign req_valid = IO_Select_H & (Read_H | Write_H);
  assign word_addr = Address & 16'hFFFC;
  // The read value is captured on the edge entering ACK; with zero wait
  // states that edge is the accepting one, so the live address is used.
  assign req_addr  = (state == IO_IDLE) ? word_addr : addr_q;
  assign commit    = (state == IO_ACK) && wr_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IO_IDLE: if (req_valid) state_nxt = (WAIT_STATES == 0) ? IO_ACK : IO_WAIT;
      IO_WAIT: if (ws_cnt == WS_LAST) state_nxt = IO_ACK;
      IO_ACK:  state_nxt = IO_DONE;
      IO_DONE: if (!IO_Select_H || (!Read_H && !Write_H)) state_nxt = IO_IDLE;
      default: state_nxt = IO_IDLE;
    endcase
    go_ack = (state != IO_ACK) && (state_nxt == IO_ACK);
  end

  always_comb begin
    rd_mux = '0;
    case (req_addr)
      IO_LED_OFS:    rd_mux = 32'(LED);
      IO_SW_OFS:     rd_mux = 32'(sw_sync);
      IO_TCOUNT_OFS: rd_mux = tcount;
      IO_TCMP_OFS:   rd_mux = tcmp;
      IO_CTRL_OFS:   rd_mux = ctrl_rd;
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    led_nxt = LED;
    if (commit && (addr_q == IO_LED_OFS)) begin
      for (int i = 0; i < LED_WIDTH; i++) begin
        if (be_q[i/8]) led_nxt[i] = wdata_q[i];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state     <= IO_IDLE;
      ws_cnt    <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      DataAck_H <= 1'b0;
      ReadData  <= '0;
      LED       <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      state     <= state_nxt;
      DataAck_H <= go_ack;
      ReadData  <= go_ack ? rd_mux : 32'd0;
      LED       <= led_nxt;
      sw_meta   <= SW;
      sw_sync   <= sw_meta;
      if ((state == IO_IDLE) && req_valid) begin
        addr_q  <= word_addr;
        be_q    <= ByteEnable;
        wdata_q <= WriteData;
        wr_q    <= Write_H;  // write wins when both strobes are high
        ws_cnt  <= '0;
      end else if (state == IO_WAIT) begin
        ws_cnt  <= ws_cnt + 4'd1;
      end
    end
  end

  io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (Clock),
    .rst       (Reset_H),
    .tcount_we (commit && (addr_q == IO_TCOUNT_OFS)),
    .tcmp_we   (commit && (addr_q == IO_TCMP_OFS)),
    .ctrl_we   (commit && (addr_q == IO_CTRL_OFS)),
    .wdata     (wdata_q),
    .be        (be_q),
    .tcount    (tcount),
    .tcmp      (tcmp),
    .ctrl_rd   (ctrl_rd),
    .irq       (Timer_IRQ_H)
  );

endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder: directed self-checking bench for io_bus_responder
// with WAIT_STATES=1, PRESCALE=2. Read expectations are queued when a read is
// driven and compared when the acknowledge arrives.
module tb_io_bus_responder;
  import io_pkg::*;

  localparam int WS = 1;

  logic        Clock = 1'b0;
  logic        Reset_H;
  logic        IO_Select_H;
  logic [15:0] Address;
  logic        Read_H;
  logic        Write_H;
  logic [3:0]  ByteEnable;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        DataAck_H;
  logic [9:0]  LED;
  logic [9:0]  SW;
  logic        Timer_IRQ_H;

  io_bus_responder #(
    .WAIT_STATES (WS),
    .LED_WIDTH   (10),
    .SW_WIDTH    (10),
    .PRESCALE    (2)
  ) dut (
    .Clock       (Clock),
    .Reset_H     (Reset_H),
    .IO_Select_H (IO_Select_H),
    .Address     (Address),
    .Read_H      (Read_H),
    .Write_H     (Write_H),
    .ByteEnable  (ByteEnable),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .DataAck_H   (DataAck_H),
    .LED         (LED),
    .SW          (SW),
    .Timer_IRQ_H (Timer_IRQ_H)
  );

  always #5 Clock = ~Clock;

  // Number of rising edges so far; read at falling edges.
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  int          last_commit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge Clock);
  endtask

  // Called at a falling edge with the responder idle. Holds the request two
  // cycles past the ack to prove it is not serviced twice, then releases it.
  task automatic xfer(input string tag, input logic rd, input logic wr,
                      input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] exp_rd);
    int          start;
    int          waited;
    logic        got;
    logic [31:0] exp;
    start       = cyc;
    IO_Select_H = 1'b1;
    Read_H      = rd;
    Write_H     = wr;
    Address     = addr;
    WriteData   = wd;
    ByteEnable  = be;
    if (rd && !wr) sb_q.push_back(exp_rd);
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      @(negedge Clock);
      waited++;
      if (DataAck_H) got = 1'b1;
      else chk({tag, "_rdata_idle"}, ReadData, 32'd0);
    end
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_ack_latency"}, 32'(cyc - start), 32'(WS + 1));
      last_commit = cyc + 1;
      if (rd && !wr) begin
        exp = sb_q.pop_front();
        chk({tag, "_rdata"}, ReadData, exp);
      end
    end
    repeat (2) begin
      @(negedge Clock);
      chk({tag, "_no_reack"}, 32'(DataAck_H), 32'd0);
      chk({tag, "_rdata_zero"}, ReadData, 32'd0);
    end
    IO_Select_H = 1'b0;
    Read_H      = 1'b0;
    Write_H     = 1'b0;
    @(negedge Clock);
    chk({tag, "_idle_ack"}, 32'(DataAck_H), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ea;
    int tgt;
    int irq_at;

    Reset_H     = 1'b1;
    IO_Select_H = 1'b0;
    Address     = '0;
    Read_H      = 1'b0;
    Write_H     = 1'b0;
    ByteEnable  = '0;
    WriteData   = '0;
    SW          = '0;
    repeat (3) @(negedge Clock);
    chk("rst_ack", 32'(DataAck_H), 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_irq", 32'(Timer_IRQ_H), 32'd0);
    Reset_H = 1'b0;
    SW      = 10'h2A5;
    @(negedge Clock);

    // LED write, byte lanes, switch read, unmapped access, dual strobes
    xfer("wr_led", 1'b0, 1'b1, IO_LED_OFS, 32'h0000_03FF, 4'hF, 32'd0);
    chk("led_after_wr", 32'(LED), 32'h3FF);
    xfer("rd_sw", 1'b1, 1'b0, IO_SW_OFS, 32'd0, 4'h0, 32'h0000_02A5);
    xfer("rd_led", 1'b1, 1'b0, IO_LED_OFS, 32'd0, 4'h0, 32'h0000_03FF);
    xfer("rd_unmapped", 1'b1, 1'b0, 16'h0020, 32'd0, 4'h0, 32'd0);
    xfer("wr_unmapped", 1'b0, 1'b1, 16'h0024, 32'hFFFF_FFFF, 4'hF, 32'd0);
    chk("led_after_unmapped", 32'(LED), 32'h3FF);
    xfer("rdwr_led", 1'b1, 1'b1, IO_LED_OFS, 32'h0000_0155, 4'hF, 32'd0);
    chk("led_write_wins", 32'(LED), 32'h155);
    // Only lane 1 written: LED[9:8] cleared, LED[7:0] kept.
    xfer("wr_led_be", 1'b0, 1'b1, IO_LED_OFS, 32'h0000_0000, 4'h2, 32'd0);
    chk("led_byte_lane", 32'(LED), 32'h055);
    // Address bits [1:0] ignored.
    xfer("rd_led_unaligned", 1'b1, 1'b0, 16'h0003, 32'd0, 4'h0, 32'h0000_0055);

    // Timer: compare 3, prescale 2. Enable commits at edge ea; ticks follow
    // at ea+2, +4, +6 (count 1,2,3) and ea+8 matches (count 0, flag set),
    // so the registered IRQ first shows after edge ea+9.
    xfer("wr_tcmp", 1'b0, 1'b1, IO_TCMP_OFS, 32'd3, 4'hF, 32'd0);
    xfer("rd_tcmp", 1'b1, 1'b0, IO_TCMP_OFS, 32'd0, 4'h0, 32'd3);
    chk("irq_idle", 32'(Timer_IRQ_H), 32'd0);
    xfer("wr_ctrl_en", 1'b0, 1'b1, IO_CTRL_OFS, 32'h5, 4'hF, 32'd0);
    ea     = last_commit;
    irq_at = -1;
    for (int i = 0; i < 30 && irq_at < 0; i++) begin
      @(negedge Clock);
      if (Timer_IRQ_H) irq_at = cyc;
    end
    chk("irq_rise_cycle", 32'(irq_at - ea), 32'd9);
    xfer("rd_ctrl_flag", 1'b1, 1'b0, IO_CTRL_OFS, 32'd0, 4'h0, 32'h7);

    // W1C landing exactly on a match edge (ea+8+8k): the flag must survive.
    tgt = ea + 8;
    while (tgt - 3 < cyc) tgt += 8;
    wait_to(tgt - 3);
    xfer("w1c_on_match", 1'b0, 1'b1, IO_CTRL_OFS, 32'h7, 4'hF, 32'd0);
    xfer("rd_ctrl_set_wins", 1'b1, 1'b0, IO_CTRL_OFS, 32'd0, 4'h0, 32'h7);

    // TCOUNT write landing on a tick edge (ea+2k): the tick is dropped. The
    // readback starts two cycles later and captures after one more tick,
    // so 0x101 is expected (0x102 had the coincident tick also counted).
    tgt = ea + 2;
    while (tgt - 3 < cyc) tgt += 2;
    wait_to(tgt - 3);
    xfer("wr_tcount_on_tick", 1'b0, 1'b1, IO_TCOUNT_OFS, 32'h100, 4'hF, 32'd0);
    xfer("rd_tcount", 1'b1, 1'b0, IO_TCOUNT_OFS, 32'd0, 4'h0, 32'h101);

    // Flag clear and IRQ drop.
    chk("irq_before_clear", 32'(Timer_IRQ_H), 32'd1);
    xfer("w1c_clear", 1'b0, 1'b1, IO_CTRL_OFS, 32'h2, 4'hF, 32'd0);
    chk("irq_after_clear", 32'(Timer_IRQ_H), 32'd0);
    xfer("rd_ctrl_cleared", 1'b1, 1'b0, IO_CTRL_OFS, 32'd0, 4'h0, 32'h0);

    // Reset during WAIT of an LED write: transfer abandoned.
    IO_Select_H = 1'b1;
    Write_H     = 1'b1;
    Address     = IO_LED_OFS;
    WriteData   = 32'h3FF;
    ByteEnable  = 4'hF;
    @(negedge Clock);
    Reset_H     = 1'b1;
    IO_Select_H = 1'b0;
    Write_H     = 1'b0;
    @(negedge Clock);
    chk("midrst_ack", 32'(DataAck_H), 32'd0);
    chk("midrst_led", 32'(LED), 32'd0);
    Reset_H = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      chk("postrst_no_ack", 32'(DataAck_H), 32'd0);
      chk("postrst_led", 32'(LED), 32'd0);
    end
    xfer("postrst_rd_led", 1'b1, 1'b0, IO_LED_OFS, 32'd0, 4'h0, 32'd0);
    xfer("postrst_rd_tcmp", 1'b1, 1'b0, IO_TCMP_OFS, 32'd0, 4'h0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Bus target for the IO region 0x00400000–0x0040FFFF. It responds to the IO select line driven by the system address decoder.
- Performs a request/acknowledge handshake with a programmable number of wait states.
- Holds memory-mapped peripheral registers: LEDs, switch input and a compare timer with an interrupt.
- Returns read data to the CPU bus read mux.

Parameters:
- WAIT_STATES, 1, idle cycles between accepting a request and asserting DataAck_H (0..15).
- LED_WIDTH, 10, implemented LED register bits.
- SW_WIDTH, 10, implemented switch input bits.
- PRESCALE, 50, clock cycles per timer tick (>=1).

Ports:
- Clock  in  1  system clock, all logic on the rising edge
- Reset_H  in  1  synchronous, active-high reset
- IO_Select_H  in  1  from the address decoder; high while Address is in the IO region
- Address  in  16  byte offset within the IO region (Address[15:0]); bits [1:0] ignored
- Read_H  in  1  read request strobe, held until acknowledged
- Write_H  in  1  write request strobe, held until acknowledged
- ByteEnable  in  4  write byte lanes
- WriteData  in  32  write data
- ReadData  out  32  read data, valid while DataAck_H=1
- DataAck_H  out  1  one-cycle transfer acknowledge
- LED  out  LED_WIDTH  LED register contents
- SW  in  SW_WIDTH  asynchronous switch inputs
- Timer_IRQ_H  out  1  level interrupt

Behaviour:
- Reset (Reset_H high at a clock edge): every output is 0. All registers are cleared, the switch synchronizer is cleared, the prescaler is cleared and the FSM goes to IDLE. Reset mid-transfer abandons the transfer with no ack and no register write.
- FSM states: IDLE, WAIT, ACK, DONE.
  - IDLE: go to WAIT when IO_Select_H & (Read_H | Write_H). Latch Address, ByteEnable, WriteData and the direction; write wins if both strobes are high. If WAIT_STATES=0, go straight to ACK.
  - WAIT: count WAIT_STATES cycles, then go to ACK.
  - ACK: DataAck_H=1 for exactly one cycle. ReadData holds the registered read value. A write commits at the end of this cycle. Next state is DONE.
  - DONE: DataAck_H=0 and ReadData=0. Stay until IO_Select_H=0 or both strobes are 0, then go to IDLE. This prevents a held request from being serviced twice.
- Latency: the ack arrives WAIT_STATES+1 cycles after the accepting edge.
- ReadData is 0 whenever DataAck_H=0.
- If IO_Select_H drops during WAIT, the FSM still completes the ACK (the latched request stands).
- Register map (word offsets):
  - 0x00 LED, RW, width LED_WIDTH, byte enables honoured.
  - 0x04 SW, RO, 2-flop synchronized, zero-extended.
  - 0x08 TCOUNT, RW, 32-bit.
  - 0x0C TCOMPARE, RW, 32-bit, reset value 0.
  - 0x10 CTRL: bit0 enable (RW), bit1 match flag (read; write 1 to clear), bit2 irq_en (RW).
  - Unmapped offsets read 0, ignore writes and are still acknowledged.
- Timer:
  - The prescaler counts 0..PRESCALE-1 while enable=1 and emits one tick per wrap. Clearing enable holds both the prescaler and TCOUNT.
  - On a tick: if TCOUNT==TCOMPARE, TCOUNT←0 and flag←1; otherwise TCOUNT←TCOUNT+1 (wraps modulo 2^32).
  - A bus write to TCOUNT in the same cycle as a tick: the bus write wins and the tick is dropped.
  - Flag set and W1C in the same cycle: set wins.
  - Timer_IRQ_H is registered as flag & irq_en, one cycle behind.

Decomposition:
- Shared package io_pkg holds:
  - the FSM state enum;
  - register offset constants (IO_LED_OFS, IO_SW_OFS, IO_TCOUNT_OFS, IO_TCMP_OFS, IO_CTRL_OFS);
  - CTRL bit index constants;
  - IO region base and limit constants, shared with the address decoder.
- One natural sub-module: io_timer, holding the prescaler, TCOUNT, the compare logic and the flag, with bus write strobes as inputs.

Test Plan:
- Reset, then WAIT_STATES=1, write 0x3FF to 0x00 with ByteEnable=0xF: DataAck_H high exactly on the 2nd cycle after acceptance; LED=0x3FF the cycle after the ack; a held strobe gets no second ack.
- SW=0x2A5 applied, then read 0x04: ack carries ReadData=0x000002A5; ReadData=0 on all other cycles.
- PRESCALE=2, TCOMPARE=3, CTRL=0x5: TCOUNT sequence 0,1,2,3,0 every 2 cycles; flag=1 at the wrap; Timer_IRQ_H rises one cycle later; writing CTRL=0x2 clears the flag and the IRQ.
- Bus write of TCOUNT=0x100 coincident with a tick: TCOUNT reads 0x100, not 0x101. Flag W1C coincident with a match: flag stays 1.
- Read 0x20 (unmapped): acked with ReadData=0. Read_H and Write_H both high to 0x00: the write is performed.
- Reset_H asserted during WAIT of a write to 0x00: no DataAck_H, LED stays 0, FSM is in IDLE after reset.
